// File: rtl/note_draw_ctrl_pkg.sv
// Shared types and constants for the note display controller: FSM encoding,
// note id values and default box geometry.
package note_draw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ERASE  = 3'd2,
    ST_DRAW   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_CS4  = 4'd2;
  localparam logic [3:0] NOTE_D4   = 4'd3;
  localparam logic [3:0] NOTE_DS4  = 4'd4;
  localparam logic [3:0] NOTE_E4   = 4'd5;
  localparam logic [3:0] NOTE_F4   = 4'd6;
  localparam logic [3:0] NOTE_FS4  = 4'd7;
  localparam logic [3:0] NOTE_G4   = 4'd8;
  localparam logic [3:0] NOTE_GS4  = 4'd9;
  localparam logic [3:0] NOTE_A4   = 4'd10;
  localparam logic [3:0] NOTE_AS4  = 4'd11;
  localparam logic [3:0] NOTE_B4   = 4'd12;
  localparam logic [3:0] NOTE_C5   = 4'd13;

  localparam logic [15:0] DEF_STABLE_CYC  = 16'd50000;
  localparam logic [7:0]  DEF_X_BASE      = 8'd20;
  localparam logic [7:0]  DEF_X_STEP      = 8'd10;
  localparam logic [6:0]  DEF_Y_BASE      = 7'd90;
  localparam logic [6:0]  DEF_Y_STEP      = 7'd4;
  localparam logic [2:0]  DEF_NOTE_COLOUR = 3'b000;
  localparam logic [2:0]  DEF_BG_COLOUR   = 3'b111;

  // Ids above C5 carry no pitch and are displayed as silence.
  function automatic logic [3:0] norm_id(input logic [3:0] id);
    return (id > NOTE_C5) ? NOTE_NONE : id;
  endfunction

endpackage

// File: rtl/note_draw_ctrl_if.sv
// Note input and vga_adapter pixel bus of the note display controller.
interface note_draw_ctrl_if;
  logic [3:0] note_id;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic [3:0] shown_id;

  modport master (output note_id, input x, y, colour, plot, busy, shown_id);
  modport slave  (input note_id, output x, y, colour, plot, busy, shown_id);
endinterface

// File: rtl/note_draw_ctrl_pos_lut.sv
// Maps a note id to the top-left corner of its 4x4 box on screen.
module note_pos_lut
  import note_draw_pkg::*;
#(
  parameter logic [7:0] X_BASE = DEF_X_BASE,
  parameter logic [7:0] X_STEP = DEF_X_STEP,
  parameter logic [6:0] Y_BASE = DEF_Y_BASE,
  parameter logic [6:0] Y_STEP = DEF_Y_STEP
) (
  input  logic [3:0] id_i,
  output logic [7:0] x0_o,
  output logic [6:0] y0_o
);

  logic [3:0] idx;
  logic [7:0] idx_x;
  logic [6:0] idx_y;

  // Wraps for id 0; callers never plot the silence box.
  assign idx   = id_i - 4'd1;
  assign idx_x = {4'd0, idx};
  assign idx_y = {3'd0, idx};
  assign x0_o  = X_BASE + idx_x * X_STEP;
  assign y0_o  = Y_BASE - idx_y * Y_STEP;

endmodule

// File: rtl/note_draw_ctrl.sv
// Waits for note_id to settle, then erases the old note box and draws the new
// one through the vga_adapter pixel bus, one pixel per cycle.
module note_draw_ctrl
  import note_draw_pkg::*;
#(
  parameter logic [15:0] STABLE_CYC  = DEF_STABLE_CYC,
  parameter logic [7:0]  X_BASE      = DEF_X_BASE,
  parameter logic [7:0]  X_STEP      = DEF_X_STEP,
  parameter logic [6:0]  Y_BASE      = DEF_Y_BASE,
  parameter logic [6:0]  Y_STEP      = DEF_Y_STEP,
  parameter logic [2:0]  NOTE_COLOUR = DEF_NOTE_COLOUR,
  parameter logic [2:0]  BG_COLOUR   = DEF_BG_COLOUR
) (
  input  logic             clock,
  input  logic             resetn,
  note_draw_ctrl_if.slave  bus
);

  state_e     state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0] prev_q, prev_d;
  logic [3:0] target_q, target_d;
  logic [3:0] shown_q, shown_d;
  logic [3:0] pix_q, pix_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;

  logic [3:0] norm;
  logic [7:0] shown_x0, target_x0, off_x;
  logic [6:0] shown_y0, target_y0, off_y;
  logic       settle_done;
  logic       pix_last;

  note_pos_lut #(.X_BASE(X_BASE), .X_STEP(X_STEP), .Y_BASE(Y_BASE), .Y_STEP(Y_STEP))
    u_lut_shown (.id_i(shown_q), .x0_o(shown_x0), .y0_o(shown_y0));

  note_pos_lut #(.X_BASE(X_BASE), .X_STEP(X_STEP), .Y_BASE(Y_BASE), .Y_STEP(Y_STEP))
    u_lut_target (.id_i(target_q), .x0_o(target_x0), .y0_o(target_y0));

  assign norm        = norm_id(bus.note_id);
  assign off_x       = {6'd0, pix_q[1:0]};
  assign off_y       = {5'd0, pix_q[3:2]};
  assign pix_last    = (pix_q == 4'd15);
  // Widened compare so STABLE_CYC = 0 still exits after one cycle.
  assign settle_done = ({1'b0, cnt_q} + 17'd1) >= {1'b0, STABLE_CYC};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    target_d = target_q;
    shown_d  = shown_q;
    pix_d    = pix_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (norm != shown_q) begin
          state_d = ST_SETTLE;
          cnt_d   = 16'd0;
          prev_d  = norm;
        end
      end
      ST_SETTLE: begin
        if (norm == shown_q) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else if (norm != prev_q) begin
          prev_d = norm;
          cnt_d  = 16'd0;
        end else if (settle_done) begin
          target_d = norm;
          cnt_d    = 16'd0;
          pix_d    = 4'd0;
          if (shown_q != NOTE_NONE)  state_d = ST_ERASE;
          else if (norm != NOTE_NONE) state_d = ST_DRAW;
          else                        state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_ERASE: begin
        x_d      = shown_x0 + off_x;
        y_d      = shown_y0 + off_y;
        colour_d = BG_COLOUR;
        plot_d   = 1'b1;
        pix_d    = pix_q + 4'd1;
        if (pix_last) state_d = (target_q != NOTE_NONE) ? ST_DRAW : ST_DONE;
      end
      ST_DRAW: begin
        x_d      = target_x0 + off_x;
        y_d      = target_y0 + off_y;
        colour_d = NOTE_COLOUR;
        plot_d   = 1'b1;
        pix_d    = pix_q + 4'd1;
        if (pix_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        shown_d = target_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 16'd0;
      prev_q   <= NOTE_NONE;
      target_q <= NOTE_NONE;
      shown_q  <= NOTE_NONE;
      pix_q    <= 4'd0;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= 3'd0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      target_q <= target_d;
      shown_q  <= shown_d;
      pix_q    <= pix_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.colour   = colour_q;
  assign bus.plot     = plot_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.shown_id = shown_q;

endmodule

// File: tb/tb_note_draw_ctrl.sv
// Directed bench for note_draw_ctrl: expected pixels are queued when a note is
// applied and popped by a monitor as plot strobes appear.
module tb_note_draw_ctrl;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk;
  logic resetn;
  int   n_pass;
  int   n_total;
  int   plots_seen;
  pix_t sb[$];
  pix_t mon_p;

  note_draw_ctrl_if bus ();

  note_draw_ctrl #(.STABLE_CYC(16'd4)) dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push_box(input int id, input logic [2:0] c);
    pix_t p;
    for (int dy = 0; dy < 4; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        p.x = 8'(20 + (id - 1) * 10 + dx);
        p.y = 7'(90 - (id - 1) * 4 + dy);
        p.c = c;
        sb.push_back(p);
      end
    end
  endtask

  task automatic wait_idle(input int exp_lat, input string tag);
    int n = 0;
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      n++;
      if (bus.busy === 1'b0) done = 1'b1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check(tag, 32'(n), 32'(exp_lat));
  endtask

  always @(negedge clk) begin
    if (bus.plot === 1'b1) begin
      plots_seen++;
      if (sb.size() == 0) begin
        check("unexpected_plot", 32'd1, 32'd0);
      end else begin
        mon_p = sb.pop_front();
        $display("plot #%0d x=%0d y=%0d colour=%b", plots_seen, bus.x, bus.y, bus.colour);
        check("px_x", 32'(bus.x), 32'(mon_p.x));
        check("px_y", 32'(bus.y), 32'(mon_p.y));
        check("px_colour", 32'(bus.colour), 32'(mon_p.c));
      end
    end
  end

  initial begin
    int base;
    clk = 1'b0;
    resetn = 1'b0;
    n_pass = 0;
    n_total = 0;
    plots_seen = 0;
    bus.note_id = 4'd0;

    repeat (3) @(negedge clk);
    check("rst_x", 32'(bus.x), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_colour", 32'(bus.colour), 32'd0);
    check("rst_plot", 32'(bus.plot), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_shown", 32'(bus.shown_id), 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // 0 -> 5: draw only
    push_box(5, 3'b000);
    bus.note_id = 4'd5;
    wait_idle(22, "lat_draw5");
    check("shown_5", 32'(bus.shown_id), 32'd5);
    check("sb_empty_5", 32'(sb.size()), 32'd0);

    // short glitch to 7 must not redraw
    base = plots_seen;
    bus.note_id = 4'd7;
    repeat (2) @(negedge clk);
    bus.note_id = 4'd5;
    repeat (10) @(negedge clk);
    check("glitch_plots", 32'(plots_seen - base), 32'd0);
    check("glitch_busy", 32'(bus.busy), 32'd0);
    check("glitch_shown", 32'(bus.shown_id), 32'd5);

    // 5 -> 13: erase then draw
    push_box(5, 3'b111);
    push_box(13, 3'b000);
    bus.note_id = 4'd13;
    wait_idle(38, "lat_13");
    check("shown_13", 32'(bus.shown_id), 32'd13);
    check("sb_empty_13", 32'(sb.size()), 32'd0);

    // 13 -> 1
    push_box(13, 3'b111);
    push_box(1, 3'b000);
    bus.note_id = 4'd1;
    wait_idle(38, "lat_1");
    check("shown_1", 32'(bus.shown_id), 32'd1);

    // id 15 counts as silence: erase only
    push_box(1, 3'b111);
    bus.note_id = 4'd15;
    wait_idle(22, "lat_15");
    check("shown_0", 32'(bus.shown_id), 32'd0);
    check("sb_empty_15", 32'(sb.size()), 32'd0);

    // reset in the middle of a draw
    push_box(5, 3'b000);
    bus.note_id = 4'd5;
    base = plots_seen;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (plots_seen - base == 8) break;
    end
    check("mid_plots", 32'(plots_seen - base), 32'd8);
    resetn = 1'b0;
    #1;
    check("mid_rst_plot", 32'(bus.plot), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_shown", 32'(bus.shown_id), 32'd0);
    sb.delete();
    push_box(5, 3'b000);
    @(negedge clk);
    resetn = 1'b1;
    wait_idle(22, "lat_redraw5");
    check("shown_redraw5", 32'(bus.shown_id), 32'd5);
    check("sb_empty_redraw", 32'(sb.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/note_draw_ctrl.md
NOTE_DRAW_CTRL -- requirements
Module: note_draw_ctrl

Interface
REQ-001 Parameter STABLE_CYC, default 16'd50000, cycles note_id must hold before a redraw starts.
REQ-002 Parameter X_BASE, default 8'd20, x of note id 1 box origin.
REQ-003 Parameter X_STEP, default 8'd10, x increment per note id.
REQ-004 Parameter Y_BASE, default 7'd90, y of note id 1 box origin.
REQ-005 Parameter Y_STEP, default 7'd4, y decrement per note id.
REQ-006 Parameter NOTE_COLOUR, default 3'b000, draw colour.
REQ-007 Parameter BG_COLOUR, default 3'b111, erase colour.
REQ-008 clock  in  1  system clock (CLOCK_50 domain).
REQ-009 resetn  in  1  asynchronous active-low reset.
REQ-010 note_id  in  4  0 = silence, 1..13 = C4..C5 ascending; 14, 15 treated as 0.
REQ-011 x  out  8  pixel x to vga_adapter.
REQ-012 y  out  7  pixel y to vga_adapter.
REQ-013 colour  out  3  pixel colour to vga_adapter.
REQ-014 plot  out  1  write strobe to vga_adapter, one pixel per high cycle.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 shown_id  out  4  note currently displayed.

Function
REQ-017 States: IDLE, SETTLE, ERASE, DRAW, DONE.
REQ-018 IDLE -> SETTLE when normalised note_id != shown_id; stability counter cleared on entry.
REQ-019 SETTLE: counter increments each cycle note_id is unchanged; any change restarts count at 0; note_id equal to shown_id returns to IDLE.
REQ-020 SETTLE exit after STABLE_CYC consecutive stable cycles; target_id latched at exit; go to ERASE if shown_id != 0, else DRAW if target_id != 0, else DONE.
REQ-021 Box origin for id n: x0 = X_BASE + (n-1)*X_STEP, y0 = Y_BASE - (n-1)*Y_STEP; 8-bit/7-bit unsigned arithmetic.
REQ-022 ERASE: 16 pixels of shown_id box, colour = BG_COLOUR, row-major scan, dx 0..3 fastest, then dy 0..3.
REQ-023 DRAW: 16 pixels of target_id box, colour = NOTE_COLOUR, same scan order.
REQ-024 ERASE -> DRAW if target_id != 0, else -> DONE; DRAW -> DONE after pixel 15.
REQ-025 x, y, colour, plot registered; plot high exactly 16 consecutive cycles per box, low otherwise.
REQ-026 DONE lasts one cycle: shown_id <= target_id, then -> IDLE.
REQ-027 note_id changes during ERASE/DRAW/DONE are ignored until IDLE re-evaluates.
REQ-028 Worst-case latency from stable note change to DONE: STABLE_CYC + 1 + 32 + 1 cycles.

Reset
REQ-029 resetn low: state IDLE, x=0, y=0, colour=0, plot=0, busy=0, shown_id=0, counters 0, immediately.
REQ-030 Reset mid-ERASE/DRAW aborts with no further plots; partial box remains in frame buffer.

Structure
REQ-031 Package note_draw_pkg holds state encoding, note id constants (NOTE_NONE, NOTE_C4..NOTE_C5), and default geometry constants.
REQ-032 Sub-module note_pos_lut: combinational id -> (x0, y0) per REQ-021, one instance each for shown_id and target_id.

Verification (STABLE_CYC=4)
REQ-033 Reset, note_id 0 -> 5 held -> SETTLE 4 cycles, 16 plots at x 60..63, y 74..77, colour 000, shown_id=5.
REQ-034 shown_id=5, note_id -> 13 -> 16 erase plots colour 111 at (60,74)..(63,77), then 16 draws at (140,42)..(143,45), shown_id=13.
REQ-035 note_id glitches 5 -> 7 for 2 cycles -> back to 5 -> SETTLE aborts to IDLE, zero plots.
REQ-036 note_id 15 while shown_id=1 -> erase 16 pixels at (20,90), no draw, shown_id=0.
REQ-037 resetn low at DRAW pixel 8 -> plot=0 same cycle, shown_id=0, busy=0; next stable note redraws fully.
